// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: parity modes,
// FSM state encoding and the parity helper.
package uart_tx_fifo_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Callers zero-extend narrower words; the padding does not change the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int mode);
    parity_bit = (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and a look-ahead read
// port (rd_data always shows the head entry). Reusable outside the UART.
module uart_tx_fifo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic [LW-1:0]    level_next;
  logic             full_reg;
  logic             empty_reg;
  logic             push;
  logic             pop;

  // Full/empty are registered, so a pop at full cannot admit a push that cycle.
  assign push = wr_en && !full_reg;
  assign pop  = rd_en && !empty_reg;

  always_comb begin
    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LW'(1);
    end else if (!push && pop) begin
      level_next = level_reg - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      level_reg <= level_next;
      full_reg  <= (level_next == LW'(DEPTH));
      empty_reg <= (level_next == '0);
    end
  end

  // Asynchronous head read keeps the pop-to-start-bit latency at one cycle.
  assign rd_data = mem[rd_ptr_reg];
  assign full    = full_reg;
  assign empty   = empty_reg;
  assign level   = level_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed by an internal FIFO; frames go out
// back-to-back while words are queued.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int CLK_DIV    = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BITS-1:0]          din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          end_of_send,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BW = $clog2(CLK_DIV + 1);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  generate
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (CLK_DIV < 1) begin : g_bad_div
      $error("uart_tx_fifo: CLK_DIV must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [DATA_BITS-1:0]          fifo_rd_data;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_pop;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level_w;
  logic [MAX_DATA_BITS-1:0]      pop_word_ext;

  tx_state_t                     state_reg;
  logic [BW-1:0]                 baud_cnt_reg;
  logic [CW-1:0]                 bit_cnt_reg;
  logic [DATA_BITS-1:0]          sreg_reg;
  logic                          parity_reg;
  logic                          tx_reg;
  logic                          eos_reg;
  logic                          bit_end;
  logic                          frame_done;

  uart_tx_fifo_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_data (din),
    .wr_en   (din_valid),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level_w)
  );

  genvar gi;
  generate
    for (gi = 0; gi < MAX_DATA_BITS; gi++) begin : g_ext
      if (gi < DATA_BITS) begin : g_bit
        assign pop_word_ext[gi] = fifo_rd_data[gi];
      end else begin : g_zero
        assign pop_word_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign bit_end    = (baud_cnt_reg == '0);
  assign frame_done = (state_reg == ST_STOP) && bit_end && (bit_cnt_reg == '0);
  // Must match exactly the FSM branches that load the shift register.
  assign fifo_pop   = !fifo_empty && ((state_reg == ST_IDLE) || frame_done);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      sreg_reg     <= '0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      eos_reg      <= 1'b0;
    end else begin
      eos_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          tx_reg <= 1'b1;
          if (!fifo_empty) begin
            state_reg    <= ST_START;
            sreg_reg     <= fifo_rd_data;
            parity_reg   <= parity_bit(pop_word_ext, PARITY);
            baud_cnt_reg <= BAUD_LOAD;
            tx_reg       <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state_reg    <= ST_DATA;
            tx_reg       <= sreg_reg[0];
            sreg_reg     <= {1'b0, sreg_reg[DATA_BITS-1:1]};
            bit_cnt_reg  <= DATA_LAST;
            baud_cnt_reg <= BAUD_LOAD;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - BW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt_reg <= BAUD_LOAD;
            if (bit_cnt_reg == '0) begin
              if (PARITY != PARITY_NONE) begin
                state_reg <= ST_PARITY;
                tx_reg    <= parity_reg;
              end else begin
                state_reg   <= ST_STOP;
                tx_reg      <= 1'b1;
                bit_cnt_reg <= STOP_LAST;
              end
            end else begin
              tx_reg      <= sreg_reg[0];
              sreg_reg    <= {1'b0, sreg_reg[DATA_BITS-1:1]};
              bit_cnt_reg <= bit_cnt_reg - CW'(1);
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - BW'(1);
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state_reg    <= ST_STOP;
            tx_reg       <= 1'b1;
            bit_cnt_reg  <= STOP_LAST;
            baud_cnt_reg <= BAUD_LOAD;
          end else begin
            baud_cnt_reg <= baud_cnt_reg - BW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt_reg <= BAUD_LOAD;
            if (bit_cnt_reg == '0) begin
              // Chain straight into the next start bit when more data is queued.
              if (!fifo_empty) begin
                state_reg  <= ST_START;
                sreg_reg   <= fifo_rd_data;
                parity_reg <= parity_bit(pop_word_ext, PARITY);
                tx_reg     <= 1'b0;
              end else begin
                state_reg <= ST_IDLE;
                eos_reg   <= 1'b1;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg - CW'(1);
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - BW'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign din_ready   = !fifo_full;
  assign tx          = tx_reg;
  assign busy        = (state_reg != ST_IDLE) || !fifo_empty;
  assign end_of_send = eos_reg;
  assign fifo_level  = fifo_level_w;

endmodule
